// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sharing one synchronous RAM between a fetch port (A) and a load/store port (B)
module ram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

    port_e last_grant;
    logic  wren_q;
    logic  s1_valid;
    port_e s1_owner;
    logic  s2_valid;
    port_e s2_owner;

    // On a conflict the port that did not win most recently gets the slot.
    always_comb begin
        a_gnt = !rst && a_req && (!b_req || (last_grant == PORT_B));
        b_gnt = !rst && b_req && (!a_req || (last_grant == PORT_A));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= PORT_B;
            ram_address  <= '0;
            ram_data     <= '0;
            wren_q       <= 1'b0;
            s1_valid     <= 1'b0;
            s1_owner     <= PORT_A;
            s2_valid     <= 1'b0;
            s2_owner     <= PORT_A;
            conflict_cnt <= '0;
        end else begin
            if (a_gnt) begin
                last_grant  <= PORT_A;
                ram_address <= a_addr;
                wren_q      <= 1'b0;
                s1_valid    <= 1'b1;
                s1_owner    <= PORT_A;
            end else if (b_gnt) begin
                last_grant  <= PORT_B;
                ram_address <= b_addr;
                ram_data    <= b_wdata;
                wren_q      <= b_we;
                s1_valid    <= !b_we;
                s1_owner    <= PORT_B;
            end else begin
                wren_q   <= 1'b0;
                s1_valid <= 1'b0;
            end
            s2_valid <= s1_valid;
            s2_owner <= s1_owner;
            if (a_req && b_req && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

    // A write already queued for the RAM is dropped if reset lands in its cycle.
    assign ram_wren = wren_q && !rst;
    assign a_rvalid = s2_valid && (s2_owner == PORT_A);
    assign b_rvalid = s2_valid && (s2_owner == PORT_B);
    assign a_rdata  = ram_q;
    assign b_rdata  = ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter
module tb_ram_arbiter;
    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic          a_gnt;
    logic          a_rvalid;
    logic [DW-1:0] a_rdata;
    logic          b_req = 1'b0;
    logic          b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_gnt;
    logic          b_rvalid;
    logic [DW-1:0] b_rdata;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q = '0;
    logic [15:0]   conflict_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_pat(input logic [11:0] a);
        return {a[3:0], a} ^ 16'hA5C3;
    endfunction

    // Single-port RAM environment: unwritten words read as init_pat, q holds on write cycles.
    logic [15:0] ram_mem [int];
    always @(posedge clk) begin
        if (ram_wren) ram_mem[int'(ram_address)] = ram_data;
        else ram_q <= ram_mem.exists(int'(ram_address)) ? ram_mem[int'(ram_address)] : init_pat(ram_address);
    end

    typedef struct {
        int          due;
        bit          port;
        logic [15:0] data;
    } ret_t;

    task automatic apply_reset();
        rst = 1'b1; a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_req = 1'b1; b_req = 1'b1; a_addr = 12'h003; b_addr = 12'h004; b_we = 1'b1; b_wdata = 16'h1111;
        #1;
        tests_run++; if (a_gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_a_gnt got %0b exp 0", a_gnt); end
        tests_run++; if (b_gnt !== 1'b0) begin tests_failed++; $display("FAIL reset_b_gnt got %0b exp 0", b_gnt); end
        @(negedge clk); #1;
        tests_run++; if (ram_wren !== 1'b0) begin tests_failed++; $display("FAIL reset_wren got %0b exp 0", ram_wren); end
        tests_run++; if (ram_address !== 12'h000) begin tests_failed++; $display("FAIL reset_addr got %0h exp 0", ram_address); end
        tests_run++; if (ram_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_data got %0h exp 0", ram_data); end
        tests_run++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid got %0b%0b exp 00", a_rvalid, b_rvalid); end
        tests_run++; if (conflict_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_cnt got %0d exp 0", conflict_cnt); end
        @(negedge clk);
        rst = 1'b0; a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
        #1;
        tests_run++; if (conflict_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_cnt_held got %0d exp 0", conflict_cnt); end
        @(negedge clk);
    endtask

    task automatic test_single_read();
        b_req = 1'b1; b_we = 1'b1; b_addr = 12'h005; b_wdata = 16'h1234;
        @(negedge clk);
        b_req = 1'b0; b_we = 1'b0;
        @(negedge clk);
        apply_reset();
        a_req = 1'b1; a_addr = 12'h005;
        #1;
        tests_run++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin tests_failed++; $display("FAIL single_gnt got %0b%0b exp 10", a_gnt, b_gnt); end
        @(negedge clk);
        a_req = 1'b0;
        #1;
        tests_run++; if (ram_address !== 12'h005) begin tests_failed++; $display("FAIL single_addr got %0h exp 5", ram_address); end
        tests_run++; if (ram_wren !== 1'b0) begin tests_failed++; $display("FAIL single_wren got %0b exp 0", ram_wren); end
        tests_run++; if (a_rvalid !== 1'b0) begin tests_failed++; $display("FAIL single_early_rvalid got %0b exp 0", a_rvalid); end
        @(negedge clk); #1;
        tests_run++; if (a_rvalid !== 1'b1 || b_rvalid !== 1'b0) begin tests_failed++; $display("FAIL single_rvalid got %0b%0b exp 10", a_rvalid, b_rvalid); end
        tests_run++; if (a_rdata !== 16'h1234) begin tests_failed++; $display("FAIL single_rdata got %0h exp 1234", a_rdata); end
        @(negedge clk); #1;
        tests_run++; if (a_rvalid !== 1'b0) begin tests_failed++; $display("FAIL single_late_rvalid got %0b exp 0", a_rvalid); end
        @(negedge clk);
    endtask

    task automatic test_conflict();
        bit            exp_port [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [AW-1:0] ex_addr [4];
        logic [AW-1:0] a_next = 12'h010;
        logic [AW-1:0] b_next = 12'h030;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                a_req = 1'b1; b_req = 1'b1; b_we = 1'b0; a_addr = a_next; b_addr = b_next;
            end else begin
                a_req = 1'b0; b_req = 1'b0;
            end
            #1;
            if (k < 4) begin
                tests_run++;
                if (a_gnt !== !exp_port[k] || b_gnt !== exp_port[k]) begin
                    tests_failed++; $display("FAIL conflict_gnt[%0d] got %0b%0b exp %0b%0b", k, a_gnt, b_gnt, !exp_port[k], exp_port[k]);
                end
                ex_addr[k] = exp_port[k] ? b_next : a_next;
                if (exp_port[k]) b_next = b_next + 12'd1; else a_next = a_next + 12'd1;
            end
            if (k >= 2) begin
                tests_run++;
                if (a_rvalid !== !exp_port[k-2] || b_rvalid !== exp_port[k-2]) begin
                    tests_failed++; $display("FAIL conflict_rvalid[%0d] got %0b%0b exp %0b%0b", k, a_rvalid, b_rvalid, !exp_port[k-2], exp_port[k-2]);
                end
                tests_run++;
                if ((exp_port[k-2] ? b_rdata : a_rdata) !== init_pat(ex_addr[k-2])) begin
                    tests_failed++; $display("FAIL conflict_rdata[%0d] got %0h exp %0h", k, exp_port[k-2] ? b_rdata : a_rdata, init_pat(ex_addr[k-2]));
                end
            end
            if (k == 4) begin
                tests_run++; if (conflict_cnt !== 16'd4) begin tests_failed++; $display("FAIL conflict_cnt got %0d exp 4", conflict_cnt); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_write_read();
        apply_reset();
        b_req = 1'b1; b_we = 1'b1; b_addr = 12'h0FF; b_wdata = 16'hBEEF;
        #1;
        tests_run++; if (b_gnt !== 1'b1) begin tests_failed++; $display("FAIL wr_gnt got %0b exp 1", b_gnt); end
        @(negedge clk);
        b_we = 1'b0;
        #1;
        tests_run++; if (b_gnt !== 1'b1) begin tests_failed++; $display("FAIL rd_gnt got %0b exp 1", b_gnt); end
        tests_run++; if (ram_wren !== 1'b1) begin tests_failed++; $display("FAIL wr_wren got %0b exp 1", ram_wren); end
        tests_run++; if (ram_address !== 12'h0FF || ram_data !== 16'hBEEF) begin tests_failed++; $display("FAIL wr_cmd got %0h/%0h exp ff/beef", ram_address, ram_data); end
        @(negedge clk);
        b_req = 1'b0;
        #1;
        tests_run++; if (ram_wren !== 1'b0) begin tests_failed++; $display("FAIL rd_wren got %0b exp 0", ram_wren); end
        tests_run++; if (b_rvalid !== 1'b0) begin tests_failed++; $display("FAIL wr_rvalid got %0b exp 0", b_rvalid); end
        @(negedge clk); #1;
        tests_run++; if (b_rvalid !== 1'b1 || a_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rd_rvalid got %0b%0b exp 01", a_rvalid, b_rvalid); end
        tests_run++; if (b_rdata !== 16'hBEEF) begin tests_failed++; $display("FAIL rd_rdata got %0h exp beef", b_rdata); end
        @(negedge clk); #1;
        tests_run++; if (b_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rd_late_rvalid got %0b exp 0", b_rvalid); end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        a_req = 1'b1; a_addr = 12'h020;
        #1;
        tests_run++; if (a_gnt !== 1'b1) begin tests_failed++; $display("FAIL mid_gnt got %0b exp 1", a_gnt); end
        @(negedge clk);
        a_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin tests_failed++; $display("FAIL mid_rvalid got %0b%0b exp 00", a_rvalid, b_rvalid); end
        tests_run++; if (ram_wren !== 1'b0 || ram_address !== 12'h000 || ram_data !== 16'h0000) begin
            tests_failed++; $display("FAIL mid_cmd got %0b/%0h/%0h exp 0/0/0", ram_wren, ram_address, ram_data);
        end
        tests_run++; if (conflict_cnt !== 16'd0) begin tests_failed++; $display("FAIL mid_cnt got %0d exp 0", conflict_cnt); end
        @(negedge clk); #1;
        tests_run++; if (a_rvalid !== 1'b0) begin tests_failed++; $display("FAIL mid_late_rvalid got %0b exp 0", a_rvalid); end
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b1; b_addr = 12'h0A0; b_wdata = 16'h7777;
        @(negedge clk);
        b_req = 1'b0; b_we = 1'b0; rst = 1'b1;
        #1;
        tests_run++; if (ram_wren !== 1'b0) begin tests_failed++; $display("FAIL drop_wren got %0b exp 0", ram_wren); end
        @(negedge clk);
        rst = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 12'h0A0;
        @(negedge clk);
        b_req = 1'b0;
        @(negedge clk); #1;
        tests_run++; if (b_rvalid !== 1'b1 || b_rdata !== init_pat(12'h0A0)) begin
            tests_failed++; $display("FAIL drop_rdata got %0b/%0h exp 1/%0h", b_rvalid, b_rdata, init_pat(12'h0A0));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        ret_t          rq[$];
        ret_t          r;
        logic [15:0]   shadow [int];
        bit            pa, pb, pb_we, ea, eb, ev_a, ev_b, m_last;
        logic [AW-1:0] pa_addr, pb_addr, e_addr;
        logic [DW-1:0] pb_data, e_data, ed;
        logic          e_wren;
        int            m_cnt;
        apply_reset();
        m_last = 1'b1; m_cnt = 0; e_addr = '0; e_data = '0; e_wren = 1'b0;
        pa = 1'b0; pb = 1'b0; pa_addr = '0; pb_addr = '0; pb_we = 1'b0; pb_data = '0;
        for (int c = 0; c < 400; c++) begin
            a_req = pa; a_addr = pa_addr; b_req = pb; b_we = pb_we; b_addr = pb_addr; b_wdata = pb_data;
            #1;
            ea = pa && (!pb || m_last);
            eb = pb && (!pa || !m_last);
            tests_run++; if (a_gnt !== ea || b_gnt !== eb) begin tests_failed++; $display("FAIL rnd_gnt c%0d got %0b%0b exp %0b%0b", c, a_gnt, b_gnt, ea, eb); end
            tests_run++; if (ram_wren !== e_wren || ram_address !== e_addr) begin
                tests_failed++; $display("FAIL rnd_cmd c%0d got %0b/%0h exp %0b/%0h", c, ram_wren, ram_address, e_wren, e_addr);
            end
            if (e_wren) begin
                tests_run++; if (ram_data !== e_data) begin tests_failed++; $display("FAIL rnd_wdata c%0d got %0h exp %0h", c, ram_data, e_data); end
            end
            ev_a = 1'b0; ev_b = 1'b0; ed = '0;
            if (rq.size() > 0 && rq[0].due == c) begin
                r = rq.pop_front();
                ev_a = !r.port; ev_b = r.port; ed = r.data;
            end
            tests_run++; if (a_rvalid !== ev_a || b_rvalid !== ev_b) begin tests_failed++; $display("FAIL rnd_rvalid c%0d got %0b%0b exp %0b%0b", c, a_rvalid, b_rvalid, ev_a, ev_b); end
            if (ev_a || ev_b) begin
                tests_run++; if ((ev_b ? b_rdata : a_rdata) !== ed) begin tests_failed++; $display("FAIL rnd_rdata c%0d got %0h exp %0h", c, ev_b ? b_rdata : a_rdata, ed); end
            end
            tests_run++; if (conflict_cnt !== 16'(m_cnt)) begin tests_failed++; $display("FAIL rnd_cnt c%0d got %0d exp %0d", c, conflict_cnt, m_cnt); end
            if (pa && pb && m_cnt < 65535) m_cnt++;
            if (ea) begin
                m_last = 1'b0; e_addr = pa_addr; e_wren = 1'b0; pa = 1'b0;
                r.due = c + 2; r.port = 1'b0;
                r.data = shadow.exists(int'(pa_addr)) ? shadow[int'(pa_addr)] : init_pat(pa_addr);
                rq.push_back(r);
            end else if (eb) begin
                m_last = 1'b1; e_addr = pb_addr; e_wren = pb_we; pb = 1'b0;
                if (pb_we) begin
                    e_data = pb_data; shadow[int'(pb_addr)] = pb_data;
                end else begin
                    r.due = c + 2; r.port = 1'b1;
                    r.data = shadow.exists(int'(pb_addr)) ? shadow[int'(pb_addr)] : init_pat(pb_addr);
                    rq.push_back(r);
                end
            end else begin
                e_wren = 1'b0;
            end
            if (!pa && $urandom_range(3) != 0) begin
                pa = 1'b1; pa_addr = 12'h100 + 12'($urandom_range(63));
            end
            if (!pb && $urandom_range(3) != 0) begin
                pb = 1'b1; pb_addr = 12'h100 + 12'($urandom_range(63));
                pb_we = 1'($urandom_range(1)); pb_data = 16'($urandom);
            end
            @(negedge clk);
        end
        a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        apply_reset();
        a_req = 1'b1; b_req = 1'b1; b_we = 1'b0; a_addr = 12'h200; b_addr = 12'h201;
        repeat (65534) @(negedge clk);
        #1;
        tests_run++; if (conflict_cnt !== 16'hFFFE) begin tests_failed++; $display("FAIL sat_pre got %0h exp fffe", conflict_cnt); end
        @(negedge clk); #1;
        tests_run++; if (conflict_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_reach got %0h exp ffff", conflict_cnt); end
        repeat (2) @(negedge clk);
        #1;
        tests_run++; if (conflict_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_hold got %0h exp ffff", conflict_cnt); end
        a_req = 1'b0; b_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests_run++; if (conflict_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_idle got %0h exp ffff", conflict_cnt); end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_read();
        test_conflict();
        test_write_read();
        test_reset_midflight();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width of the shared RAM.
REQ-002 Parameter DATA_W, default 16, data width of the shared RAM.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a_req  input  1  port A (instruction fetch) read request; held until granted.
REQ-006 a_addr  input  ADDR_W  port A read address.
REQ-007 a_gnt  output  1  port A request accepted this cycle (combinational).
REQ-008 a_rvalid  output  1  port A read data valid.
REQ-009 a_rdata  output  DATA_W  port A read data.
REQ-010 b_req  input  1  port B (load/store) request; held until granted.
REQ-011 b_we  input  1  port B write when 1, read when 0.
REQ-012 b_addr  input  ADDR_W  port B address.
REQ-013 b_wdata  input  DATA_W  port B write data.
REQ-014 b_gnt  output  1  port B request accepted this cycle (combinational).
REQ-015 b_rvalid  output  1  port B read data valid (never for writes).
REQ-016 b_rdata  output  DATA_W  port B read data.
REQ-017 ram_address  output  ADDR_W  registered RAM address.
REQ-018 ram_data  output  DATA_W  registered RAM write data.
REQ-019 ram_wren  output  1  registered RAM write enable.
REQ-020 ram_q  input  DATA_W  RAM read data, valid one clock after address registered, not updated on write cycles.
REQ-021 conflict_cnt  output  16  count of cycles with a_req and b_req both high.

Function
REQ-022 Acceptance: a request is accepted in a cycle where req and gnt are both high; at most one of a_gnt, b_gnt high per cycle; gnt never high without its req.
REQ-023 Arbitration: single requester always granted same cycle; both requesting -> grant the port not granted most recently (round-robin, 1-bit last_grant register updated on each acceptance).
REQ-024 Command stage: on acceptance in cycle n, ram_address/ram_data/ram_wren carry that command in cycle n+1; ram_wren = b_we for port B, 0 for port A.
REQ-025 Idle cycle (no acceptance): ram_wren <= 0; ram_address and ram_data hold previous values.
REQ-026 Read return: read accepted in cycle n -> owning port rvalid high for exactly cycle n+2 with rdata = ram_q; other port rvalid low.
REQ-027 rdata outputs equal ram_q at all times; only rvalid is meaningful.
REQ-028 Throughput: one access per cycle, back-to-back from either port or alternating; a port holding req after gnt is a new request.
REQ-029 Write then read same address on consecutive accepted cycles: read returns newly written data.
REQ-030 conflict_cnt increments by 1 each cycle a_req & b_req (regardless of rst-free grant outcome), saturates at 16'hFFFF.
REQ-031 In-flight tracking: 2-stage valid/owner pipeline; no other state machine.

Reset
REQ-032 rst high at an edge: ram_wren=0, ram_address=0, ram_data=0, a_rvalid=b_rvalid=0, last_grant=B (so A wins first conflict), conflict_cnt=0.
REQ-033 During rst high: a_gnt=b_gnt=0, no acceptance, conflict_cnt not incremented.
REQ-034 Reset mid-operation: in-flight reads discarded (no rvalid after reset); a write registered but not yet performed when rst asserts is dropped (ram_wren forced 0).

Verification
REQ-035 After reset, a_req=1 a_addr=0x005, RAM[5]=0x1234 -> a_gnt cycle n, ram_address=0x005 ram_wren=0 in n+1, a_rvalid with a_rdata=0x1234 in n+2.
REQ-036 First conflict after reset, both req held 4 cycles -> grants A,B,A,B; conflict_cnt=4; rvalids alternate A,B,A,B two cycles after each grant.
REQ-037 b_we=1 b_addr=0x0FF b_wdata=0xBEEF, next cycle b_we=0 b_addr=0x0FF -> ram_wren=1 one cycle then 0; b_rvalid once with b_rdata=0xBEEF; no b_rvalid for the write.
REQ-038 Reset asserted cycle after a read acceptance -> no rvalid ever for that read; all outputs at reset values.
REQ-039 Force conflict_cnt to 0xFFFE, 3 conflict cycles -> reads 0xFFFF and holds.
